// File: rtl/flit_packet_rx.sv
// flit_packet_rx: receive end of the adder-characterization flit link.
// Optional pattern checker enabled by defining PATTERN_CHECK_EN.
module flit_packet_rx #(
    parameter int FLIT_W  = 20,
    parameter int PAYLOAD = 20,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flit_valid,
    input  logic [FLIT_W-1:0] flit_data,
    output logic              flit_ready,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  flit_count,
    output logic [CNT_W-1:0]  toggle_count,
    output logic [CNT_W-1:0]  idle_count
);

    localparam int IDX_W = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;
    localparam int POP_W = $clog2(FLIT_W + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  flit_idx;
    logic [FLIT_W-1:0] last_flit;
    logic              xfer;
    logic              last_beat;
    logic              err_next;
    logic [FLIT_W-1:0] flit_diff;
    logic [POP_W-1:0]  pop;
    logic [SUM_W-1:0]  tog_sum;

    // Ready is a pure decode of the state register, never of inputs.
    assign flit_ready = (state != S_DONE);
    assign xfer       = flit_valid && flit_ready;
    assign last_beat  = xfer && (flit_idx == LAST_IDX);
    assign flit_diff  = flit_data ^ last_flit;
    assign tog_sum    = SUM_W'(toggle_count) + SUM_W'(pop);

    // Count the bits that changed relative to the previous accepted flit.
    always_comb begin
        pop = '0;
        for (int i = 0; i < FLIT_W; i++) begin
            pop = pop + POP_W'(flit_diff[i]);
        end
    end

`ifdef PATTERN_CHECK_EN
    logic [2:0]        pat_idx;
    logic [FLIT_W-1:0] pat_exp;
    logic              err_flag;
    logic              flit_bad;

    // Expected word for the current position in the 5-word cycle.
    always_comb begin
        pat_exp = '0;
        unique case (pat_idx)
            3'd0:    pat_exp = FLIT_W'(20'hFFFF0);
            3'd1:    pat_exp = FLIT_W'(20'h000FF);
            3'd2:    pat_exp = FLIT_W'(20'hFF000);
            3'd3:    pat_exp = FLIT_W'(20'h0FFFF);
            default: pat_exp = FLIT_W'(20'h00000);
        endcase
    end

    assign flit_bad = (flit_data != pat_exp);
    // Last flit's mismatch must reach pkt_err on the same edge.
    assign err_next = err_flag | flit_bad;

    // Pattern position and sticky error, restarted for every packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_idx  <= '0;
            err_flag <= 1'b0;
        end else if (state == S_DONE) begin
            pat_idx  <= '0;
            err_flag <= 1'b0;
        end else if (xfer) begin
            pat_idx  <= (pat_idx == 3'd4) ? 3'd0 : pat_idx + 3'd1;
            err_flag <= err_next;
        end
    end
`else
    assign err_next = 1'b0;
`endif

    // Packet FSM; done/err pulses are registered on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            flit_idx <= '0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            unique case (state)
                S_IDLE, S_RECV: begin
                    if (last_beat) begin
                        state    <= S_DONE;
                        pkt_done <= 1'b1;
                        pkt_err  <= err_next;
                    end else if (xfer) begin
                        state    <= S_RECV;
                        flit_idx <= flit_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    flit_idx <= '0;
                end
                default: begin
                    state    <= S_IDLE;
                    flit_idx <= '0;
                end
            endcase
        end
    end

    // Saturating activity statistics and the toggle reference flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count    <= '0;
            flit_count   <= '0;
            toggle_count <= '0;
            idle_count   <= '0;
            last_flit    <= '0;
        end else begin
            if (last_beat && pkt_count != CNT_MAX) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (xfer) begin
                last_flit <= flit_data;
                if (flit_count != CNT_MAX) begin
                    flit_count <= flit_count + 1'b1;
                end
                if (tog_sum > SUM_W'(CNT_MAX)) begin
                    toggle_count <= CNT_MAX;
                end else begin
                    toggle_count <= tog_sum[CNT_W-1:0];
                end
            end
            if (state == S_IDLE && !flit_valid &&
                idle_count != CNT_MAX) begin
                idle_count <= idle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flit_packet_rx.sv
// tb_flit_packet_rx: directed packet-level bench for flit_packet_rx.
// Second instance with CNT_W=4 exercises counter saturation.
module tb_flit_packet_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flit_valid = 1'b0;
    logic [19:0] flit_data = '0;
    logic        flit_ready, pkt_done, pkt_err;
    logic [31:0] pkt_count, flit_count, toggle_count, idle_count;
    logic        s_ready, s_done, s_err;
    logic [3:0]  s_pkt, s_flit, s_tog, s_idle;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef PATTERN_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    flit_packet_rx #(.FLIT_W(20), .PAYLOAD(20), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .flit_valid(flit_valid), .flit_data(flit_data),
        .flit_ready(flit_ready), .pkt_done(pkt_done),
        .pkt_err(pkt_err), .pkt_count(pkt_count),
        .flit_count(flit_count), .toggle_count(toggle_count),
        .idle_count(idle_count)
    );

    flit_packet_rx #(.FLIT_W(20), .PAYLOAD(20), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .flit_valid(flit_valid), .flit_data(flit_data),
        .flit_ready(s_ready), .pkt_done(s_done),
        .pkt_err(s_err), .pkt_count(s_pkt),
        .flit_count(s_flit), .toggle_count(s_tog),
        .idle_count(s_idle)
    );

    typedef struct {
        logic        rst_before;
        int          bad_idx;
        logic [19:0] bad_val;
        int          gap;
        logic        exp_err;
        int          exp_pkts;
        int          exp_flits;
        int          exp_tog;
        int          exp_idle;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [19:0] pat(input int k);
        case (k % 5)
            0:       pat = 20'hFFFF0;
            1:       pat = 20'h000FF;
            2:       pat = 20'hFF000;
            3:       pat = 20'h0FFFF;
            default: pat = 20'h00000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        flit_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one flit; returns at the negedge after it was taken.
    task automatic send_flit(input logic [19:0] d);
        int w;
        flit_valid = 1'b1;
        flit_data  = d;
        w = 0;
        while (!flit_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!flit_ready) chk("accept_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic send_packet(input int bad_idx,
                               input logic [19:0] bad_val);
        for (int k = 0; k < 20; k++) begin
            send_flit((k == bad_idx) ? bad_val : pat(k));
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, -1, 20'h0, 0, 1'b0, 1, 20, 320, 0};
        vecs[1] = '{1'b0, 3, 20'h12345, 0, ERR_EXP, 2, 40, 626, 0};
        vecs[2] = '{1'b0, -1, 20'h0, 7, 1'b0, 3, 60, 946, 6};
        for (int i = 1; i <= 10; i++) begin
            vecs[2+i] = '{(i == 1), -1, 20'h0, 7, 1'b0,
                          i, 20 * i, 320 * i, 6 * i};
        end

        for (int r = 0; r < 13; r++) begin
            if (vecs[r].rst_before) do_reset();
            send_packet(vecs[r].bad_idx, vecs[r].bad_val);
            chk($sformatf("v%0d_done", r), pkt_done, 1);
            chk($sformatf("v%0d_err", r), pkt_err, vecs[r].exp_err);
            chk($sformatf("v%0d_ready_done", r), flit_ready, 0);
            if (vecs[r].gap > 0) begin
                flit_valid = 1'b0;
                @(negedge clk);
                chk($sformatf("v%0d_done_1cyc", r), pkt_done, 0);
                repeat (vecs[r].gap - 1) @(negedge clk);
            end
            chk($sformatf("v%0d_pkts", r), pkt_count, vecs[r].exp_pkts);
            chk($sformatf("v%0d_flits", r), flit_count, vecs[r].exp_flits);
            chk($sformatf("v%0d_tog", r), toggle_count, vecs[r].exp_tog);
            chk($sformatf("v%0d_idle", r), idle_count, vecs[r].exp_idle);
        end

        // Valid held through DONE: no transfer there, taken next cycle.
        do_reset();
        send_packet(-1, 20'h0);
        flit_valid = 1'b1;
        flit_data  = pat(0);
        chk("hold_ready_done", flit_ready, 0);
        @(posedge clk);
        #1;
        chk("hold_no_xfer", flit_count, 20);
        @(negedge clk);
        chk("hold_ready_idle", flit_ready, 1);
        @(posedge clk);
        #1;
        chk("hold_xfer", flit_count, 21);
        chk("hold_tog", toggle_count, 336);
        @(negedge clk);
        for (int k = 1; k < 20; k++) send_flit(pat(k));
        chk("hold_done2", pkt_done, 1);
        chk("hold_pkts", pkt_count, 2);
        chk("hold_flits", flit_count, 40);
        chk("hold_tog2", toggle_count, 640);

        // Reset in the middle of a packet discards it.
        do_reset();
        for (int k = 0; k < 10; k++) send_flit(pat(k));
        chk("mid_flits", flit_count, 10);
        rst_n = 1'b0;
        #1;
        chk("rst_done", pkt_done, 0);
        chk("rst_err", pkt_err, 0);
        chk("rst_pkts", pkt_count, 0);
        chk("rst_flits", flit_count, 0);
        chk("rst_tog", toggle_count, 0);
        chk("rst_idle", idle_count, 0);
        flit_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold_done", pkt_done, 0);
        rst_n = 1'b1;
        chk("rst_ready", flit_ready, 1);
        @(negedge clk);
        chk("rst_idle1", idle_count, 1);
        send_packet(-1, 20'h0);
        chk("post_done", pkt_done, 1);
        chk("post_err", pkt_err, 0);
        chk("post_pkts", pkt_count, 1);
        chk("post_flits", flit_count, 20);
        chk("post_tog", toggle_count, 320);
        chk("post_idle", idle_count, 1);
        chk("sat_done", s_done, 1);
        chk("sat_pkts", s_pkt, 1);
        chk("sat_flits", s_flit, 15);
        chk("sat_tog", s_tog, 15);
        flit_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
